// File: rtl/md_unit_ctrl_if.sv
// E-stage <-> multiply/divide unit bundle: operation request in, busy and HI/LO out.
// Pure wiring, no latency of its own.
// No backpressure here; the unit's busy output is what the D-stage stall logic consumes.
interface md_unit_ctrl_if;
    logic [2:0]  md_op;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // E stage drives the request and reads busy/HI/LO
    modport master (output md_op, output start, output a, output b,
                    input  busy,  input  hi,    input  lo);

    // The multiply/divide unit consumes the request and owns busy/HI/LO
    modport slave  (input  md_op, input  start, input  a, input  b,
                    output busy,  output hi,    output lo);
endinterface

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO for the E stage (mult/multu/div/divu/mthi/mtlo).
// mult/multu: MULT_CYCLES busy cycles, div/divu: DIV_CYCLES; mthi/mtlo write HI/LO at the issuing edge.
// No handshake back-pressure: requests seen while busy are dropped; the D-stage stalls on busy instead.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic          clk,
    input  logic          reset,
    md_unit_ctrl_if.slave md_if
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    // Result datapath, evaluated from the operands latched at start
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;
    logic [31:0] div_den;
    logic [31:0] sden;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    assign md_if.busy = busy_q;
    assign md_if.hi   = hi_q;
    assign md_if.lo   = lo_q;

    // Compute the HI/LO value the running operation will commit on its last cycle
    always_comb begin
        // Sign-extending to 64 bits makes the low 64 bits of the product the signed result
        prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u  = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide via magnitudes: quotient sign is the XOR of operand signs,
        // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_mag   = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag   = b_q[31] ? (~b_q + 32'd1) : b_q;
        // Zero divisors are replaced so the divider never sees 0; the result is discarded anyway
        sden    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        div_den = (b_q   == 32'd0) ? 32'd1 : b_q;
        udiv_q  = a_mag / sden;
        udiv_r  = a_mag % sden;
        sdiv_q  = (a_q[31] ^ b_q[31]) ? (~udiv_q + 32'd1) : udiv_q;
        sdiv_r  = a_q[31] ? (~udiv_r + 32'd1) : udiv_r;

        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    lo_d = sdiv_q;
                    hi_d = sdiv_r;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    lo_d = a_q / div_den;
                    hi_d = a_q % div_den;
                end
            end
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        endcase
    end

    // IDLE/RUN sequencer: latch operands on start, count down, commit HI/LO on the final edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_if.start) begin
                        case (md_if.md_op)
                            OP_MULT, OP_MULTU: begin
                                op_q    <= md_if.md_op;
                                a_q     <= md_if.a;
                                b_q     <= md_if.b;
                                cnt_q   <= CNT_W'(MULT_CYCLES);
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q    <= md_if.md_op;
                                a_q     <= md_if.a;
                                b_q     <= md_if.b;
                                cnt_q   <= CNT_W'(DIV_CYCLES);
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end
                            OP_MTHI: hi_q <= md_if.a;
                            OP_MTLO: lo_q <= md_if.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // New requests are ignored here; only the countdown advances
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus pushes expected busy length and HI/LO,
// a monitor pops on every busy 1->0 transition, direct checks cover mthi/mtlo/no-ops/reset.
// Inputs are driven on the falling edge; the monitor samples 1 time unit after the rising edge.
module tb_md_unit_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;

    md_unit_ctrl_if md_if ();

    md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .md_if (md_if)
    );

    typedef struct {
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference semantics of the unit, written with 64-bit integer arithmetic
    task automatic ref_result(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                              output logic [31:0] eh, output logic [31:0] el);
        longint          sp;
        longint unsigned up;
        longint          sq;
        longint          sr;
        eh = model_hi;
        el = model_lo;
        case (op)
            3'd1: begin
                sp = longint'($signed(av)) * longint'($signed(bv));
                eh = sp[63:32];
                el = sp[31:0];
            end
            3'd2: begin
                up = longint'({32'd0, av}) * longint'({32'd0, bv});
                eh = up[63:32];
                el = up[31:0];
            end
            3'd3: if (bv != 0) begin
                sq = longint'($signed(av)) / longint'($signed(bv));
                sr = longint'($signed(av)) % longint'($signed(bv));
                el = sq[31:0];
                eh = sr[31:0];
            end
            3'd4: if (bv != 0) begin
                el = av / bv;
                eh = av % bv;
            end
            default: ;
        endcase
    endtask

    // Monitor: each busy run ends with a scoreboard pop; reset discards anything in flight
    initial begin
        int run;
        bit prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                sb.delete();
                run  = 0;
                prev = 1'b0;
            end else begin
                if (md_if.busy) begin
                    run++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_completion", 64'(run), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("busy_len", 64'(run), 64'(e.len));
                        check("sb_hi", {32'd0, md_if.hi}, {32'd0, e.hi});
                        check("sb_lo", {32'd0, md_if.lo}, {32'd0, e.lo});
                    end
                    run = 0;
                end
                prev = md_if.busy;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
    endtask

    // Issue one operation; with disturb set, operands and start are scrambled while busy
    task automatic do_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input bit disturb);
        logic [31:0] eh;
        logic [31:0] el;
        exp_t e;
        int   i;
        @(negedge clk);
        md_if.md_op = op;
        md_if.start = 1'b1;
        md_if.a     = av;
        md_if.b     = bv;
        if (op >= 3'd1 && op <= 3'd4) begin
            ref_result(op, av, bv, eh, el);
            e.len = (op <= 3'd2) ? MULT_N : DIV_N;
            e.hi  = eh;
            e.lo  = el;
            sb.push_back(e);
            model_hi = eh;
            model_lo = el;
        end
        @(negedge clk);
        md_if.start = 1'b0;
        md_if.md_op = 3'd0;
        if (op >= 3'd1 && op <= 3'd4) begin
            check("busy_rise", {63'd0, md_if.busy}, 64'd1);
            i = 0;
            while (md_if.busy && i < 40) begin
                if (disturb) begin
                    md_if.a     = $urandom;
                    md_if.b     = $urandom;
                    md_if.md_op = 3'($urandom_range(0, 7));
                    md_if.start = 1'b1;
                end
                @(negedge clk);
                i++;
            end
            md_if.start = 1'b0;
            md_if.md_op = 3'd0;
            if (md_if.busy) check("busy_timeout", 64'd1, 64'd0);
        end else if (op == 3'd5) begin
            model_hi = av;
            check("mthi_busy", {63'd0, md_if.busy}, 64'd0);
            check("mthi_hi", {32'd0, md_if.hi}, {32'd0, av});
        end else if (op == 3'd6) begin
            model_lo = av;
            check("mtlo_busy", {63'd0, md_if.busy}, 64'd0);
            check("mtlo_lo", {32'd0, md_if.lo}, {32'd0, av});
        end else begin
            check("nop_busy", {63'd0, md_if.busy}, 64'd0);
            check("nop_hilo", {md_if.hi, md_if.lo}, {model_hi, model_lo});
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        md_if.md_op = 3'd0;
        md_if.start = 1'b0;
        md_if.a     = 32'd0;
        md_if.b     = 32'd0;
        do_reset();

        // Reset state holds while idle
        for (int k = 0; k < 20; k++) begin
            check("idle_busy", {63'd0, md_if.busy}, 64'd0);
            check("idle_hilo", {md_if.hi, md_if.lo}, 64'd0);
            @(negedge clk);
        end

        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_hilo", {md_if.hi, md_if.lo}, 64'h0000_0001_FFFF_FFFE);

        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        do_op(3'd5, 32'h11, 32'd0, 1'b0);
        do_op(3'd6, 32'h22, 32'd0, 1'b0);
        do_op(3'd4, 32'd7, 32'd0, 1'b0);
        check("divu0_hilo", {md_if.hi, md_if.lo}, 64'h0000_0011_0000_0022);

        do_op(3'd5, 32'h1234, 32'd0, 1'b0);
        check("mthi_const", {32'd0, md_if.hi}, 64'h1234);

        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_hilo", {md_if.hi, md_if.lo}, 64'h0000_0000_8000_0000);

        // Starts while busy must be ignored; the original result still lands on schedule
        do_op(3'd1, 32'd5, 32'd7, 1'b1);
        check("busy_start_hilo", {md_if.hi, md_if.lo}, 64'd35);
        do_op(3'd4, 32'd100, 32'd7, 1'b1);
        check("busy_start_divu", {md_if.hi, md_if.lo}, {32'd2, 32'd14});

        // Reset during the third busy cycle aborts the multiply
        @(negedge clk);
        md_if.md_op = 3'd1;
        md_if.start = 1'b1;
        md_if.a     = 32'd1000;
        md_if.b     = 32'd1000;
        @(negedge clk);
        md_if.start = 1'b0;
        md_if.md_op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        check("rst_run_busy", {63'd0, md_if.busy}, 64'd0);
        check("rst_run_hilo", {md_if.hi, md_if.lo}, 64'd0);
        for (int k = 0; k < 12; k++) @(negedge clk);
        check("rst_run_hold", {md_if.hi, md_if.lo}, 64'd0);

        // Randomized operation mix
        for (int k = 0; k < 80; k++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 3; k++) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
